// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a 4:1 4-bit multiplexer.
// A winner may hold the grant for up to BURST_LEN back-to-back transfers,
// after which ownership rotates. Outputs toward the mux are registered so
// sel only moves together with out_valid/transfer edges.
module mux_sel_arbiter #(
  parameter int BURST_LEN = 2,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       out_valid,
  output logic [3:0] ack
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

  state_t           state, state_nx;
  logic [1:0]       sel_nx, last, last_nx;
  logic [3:0]       gnt_nx;
  logic             valid_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic       xfer;
  logic       cont;
  logic [3:0] others;
  logic [2:0] pick_idle;
  logic [2:0] pick_rot;

  // Returns {found, index}: first set bit of mask searching upward from start, wrapping 3->0.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!rr_pick[2] && mask[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign xfer      = out_valid & out_ready;
  assign ack       = gnt & {4{xfer}};
  assign cont      = req[sel] && (cnt < CNT_MAX);
  assign others    = req & ~(4'b0001 << sel);
  assign pick_idle = rr_pick(req, last + 2'd1);
  assign pick_rot  = rr_pick(others, sel + 2'd1);

  // State and registered mux-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
      cnt       <= '0;
      last      <= 2'd3;
    end else begin
      state     <= state_nx;
      sel       <= sel_nx;
      gnt       <= gnt_nx;
      out_valid <= valid_nx;
      cnt       <= cnt_nx;
      last      <= last_nx;
    end
  end

  // Next-state: grant from idle, extend burst, rotate, re-grant or drop to idle.
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    gnt_nx   = gnt;
    valid_nx = out_valid;
    cnt_nx   = cnt;
    last_nx  = last;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nx = BUSY;
          sel_nx   = pick_idle[1:0];
          gnt_nx   = 4'b0001 << pick_idle[1:0];
          valid_nx = 1'b1;
          cnt_nx   = '0;
        end
      end
      BUSY: begin
        if (xfer) begin
          if (cont) begin
            cnt_nx = cnt + CNT_W'(1);
          end else begin
            last_nx = sel;
            cnt_nx  = '0;
            if (pick_rot[2]) begin
              sel_nx = pick_rot[1:0];
              gnt_nx = 4'b0001 << pick_rot[1:0];
            end else if (!req[sel]) begin
              state_nx = IDLE;
              valid_nx = 1'b0;
              gnt_nx   = '0;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: four instances (BURST_LEN 2,1,3,4) share the
// stimulus and are compared each cycle against a behavioural model.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;

  logic [1:0] sel_o [4];
  logic [3:0] gnt_o [4];
  logic       val_o [4];
  logic [3:0] ack_o [4];

  int checks   = 0;
  int failures = 0;

  int bl [4] = '{2, 1, 3, 4};
  int mv [4];
  int ms [4];
  int mn [4];
  int ml [4];

  mux_sel_arbiter #(.BURST_LEN(2), .CNT_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .sel(sel_o[0]), .gnt(gnt_o[0]), .out_valid(val_o[0]), .ack(ack_o[0]));
  mux_sel_arbiter #(.BURST_LEN(1), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .sel(sel_o[1]), .gnt(gnt_o[1]), .out_valid(val_o[1]), .ack(ack_o[1]));
  mux_sel_arbiter #(.BURST_LEN(3), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .sel(sel_o[2]), .gnt(gnt_o[2]), .out_valid(val_o[2]), .ack(ack_o[2]));
  mux_sel_arbiter #(.BURST_LEN(4), .CNT_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .sel(sel_o[3]), .gnt(gnt_o[3]), .out_valid(val_o[3]), .ack(ack_o[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_req(input int start, input logic [3:0] r, input int excl);
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (start + i) % 4;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mv[k] = 0; ms[k] = 0; mn[k] = 0; ml[k] = 3;
    end
  endtask

  // Advance the model by one rising edge using the currently applied inputs.
  task automatic model_update();
    for (int k = 0; k < 4; k++) begin
      int p;
      if (mv[k] == 0) begin
        if (req != 4'b0) begin
          mv[k] = 1;
          ms[k] = first_req((ml[k] + 1) % 4, req, -1);
          mn[k] = 0;
        end
      end else if (out_ready) begin
        if (req[ms[k]] && (mn[k] + 1 < bl[k])) begin
          mn[k] = mn[k] + 1;
        end else begin
          ml[k] = ms[k];
          p = first_req((ms[k] + 1) % 4, req, ms[k]);
          if (p >= 0) begin
            ms[k] = p; mn[k] = 0;
          end else if (req[ms[k]]) begin
            mn[k] = 0;
          end else begin
            mv[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] eg;
      logic [3:0] ea;
      eg = (mv[k] != 0) ? (4'b0001 << ms[k]) : 4'b0000;
      ea = ((mv[k] != 0) && out_ready && rst_n) ? eg : 4'b0000;
      chk($sformatf("%s_sel%0d", tag, k), {2'b00, sel_o[k]}, 4'(ms[k]));
      chk($sformatf("%s_gnt%0d", tag, k), gnt_o[k], eg);
      chk($sformatf("%s_val%0d", tag, k), {3'b000, val_o[k]}, 4'(mv[k]));
      chk($sformatf("%s_ack%0d", tag, k), ack_o[k], ea);
    end
  endtask

  // Apply inputs in the low clock phase and check settled outputs.
  task automatic drive(input string tag, input logic [3:0] r, input logic rdy);
    req = r;
    out_ready = rdy;
    #1;
    check_all(tag);
  endtask

  task automatic adv();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse in the middle of the low phase; released at the next falling edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = 4'b1111;
    out_ready = 1'b0;
    model_reset();
    #2;
    check_all("reset_async");
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, burst 2
    for (int c = 0; c < 5; c++) begin
      drive("single", 4'b0100, 1'b1);
      if (c >= 1) begin
        chk("single_sel_const", {2'b00, sel_o[0]}, 4'd2);
        chk("single_ack_const", ack_o[0], 4'b0100);
      end
      adv();
    end
    for (int c = 0; c < 3; c++) begin
      drive("single_drop", 4'b0000, 1'b1);
      adv();
    end
    chk("single_idle_val", {3'b000, val_o[0]}, 4'd0);

    // Full rotation with BURST_LEN=1
    do_reset("rst_rot");
    for (int c = 0; c < 9; c++) begin
      drive("rot", 4'b1111, 1'b1);
      if (c >= 1) chk("rot_seq", {2'b00, sel_o[1]}, 4'((c - 1) % 4));
      adv();
    end

    // Bursts of three between requesters 0 and 1
    do_reset("rst_burst");
    for (int c = 0; c < 10; c++) begin
      drive("burst", 4'b0011, 1'b1);
      if (c >= 1) chk("burst_seq", {2'b00, sel_o[2]}, 4'(((c - 1) / 3) % 2));
      adv();
    end

    // Backpressure: grant on requester 1, stall, then requester 3 takes over
    do_reset("rst_bp");
    drive("bp_grant", 4'b0010, 1'b0);
    adv();
    for (int c = 0; c < 5; c++) begin
      drive("bp_stall", 4'b1000, 1'b0);
      chk("bp_sel_const", {2'b00, sel_o[0]}, 4'd1);
      chk("bp_ack_const", ack_o[0], 4'b0000);
      adv();
    end
    drive("bp_release", 4'b1000, 1'b1);
    chk("bp_ack_once", ack_o[0], 4'b0010);
    adv();
    drive("bp_after", 4'b1000, 1'b1);
    chk("bp_sel_next", {2'b00, sel_o[0]}, 4'd3);
    adv();

    // Reset in the middle of a burst on requester 2
    do_reset("rst_mid_pre");
    for (int c = 0; c < 3; c++) begin
      drive("mid", 4'b0100, 1'b1);
      adv();
    end
    req = 4'b0101;
    do_reset("rst_mid");
    drive("mid_after", 4'b0101, 1'b1);
    adv();
    drive("mid_first", 4'b0101, 1'b1);
    chk("mid_first_sel", {2'b00, sel_o[3]}, 4'd0);
    adv();

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 400; c++) begin
      drive("rand", 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 63) == 0) do_reset("rand_rst");
      else adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
